sync_rom: RTL and testbench

Synchronous, read-only lookup memory of 32 words × 5 bits with a registered output. It is addressed by a 5-bit address and gated by a read enable. It serves as a constant-table source (coefficients, codes) for downstream logic in the same clock domain. Contents are fixed at elaboration; there is no write path.

---
 rtl/rom_pkg.sv | 15 +
 rtl/rom_table.sv | 24 ++
 rtl/sync_rom.sv | 47 ++++
 tb/tb_sync_rom.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared constants and the content rule for the 32x5 constant lookup ROM.
// The rule (13*a + 7) mod 32 is a bijection over 5-bit addresses.
package rom_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 5;
    localparam int DEPTH  = 32;

    function automatic logic [DATA_W-1:0] rom_word(input int unsigned addr);
        int unsigned prod_s;
        prod_s = (addr * 32'd13) + 32'd7;
        return DATA_W'(prod_s % 32'd32);
    endfunction

endpackage

// File: rtl/rom_table.sv
// Combinational address-to-word lookup; the table is built at elaboration from rom_word.
// Addresses at or beyond DEPTH read zero when the parameters leave the space partly unpopulated.
module rom_table #(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W,
    parameter int DEPTH  = rom_pkg::DEPTH
) (
    input  logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] word
);
    import rom_pkg::*;

    logic [DATA_W-1:0] table_s [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign table_s[g] = DATA_W'(rom_word(32'(g)));
    end

    // Select the entry; a ternary lets an unknown address propagate as unknown data.
    always_comb begin
        word = (32'(adr) < 32'(DEPTH)) ? table_s[adr] : {DATA_W{1'b0}};
    end

endmodule

// File: rtl/sync_rom.sv
// Synchronous read-only constant table: enable-gated output register plus a one-cycle valid flag.
// There is no write path and the contents are independent of reset.
module sync_rom #(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W,
    parameter int DEPTH  = rom_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] data,
    output logic              data_valid
);
    import rom_pkg::*;

    logic [DATA_W-1:0] word_s;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    rom_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .adr  (adr),
        .word (word_s)
    );

    // Output register: loads on enabled edges, holds otherwise; valid pulses per load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (en) begin
            data_r  <= word_s;
            valid_r <= 1'b1;
        end else begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end
    end

    assign data       = data_r;
    assign data_valid = valid_r;

endmodule

// File: tb/tb_sync_rom.sv
// Self-checking bench for sync_rom: directed table points, enable gating, exhaustive sweep,
// asynchronous reset behaviour and randomized reads against an arithmetic reference model.
module tb_sync_rom;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [4:0] adr = 5'd0;
    logic [4:0] data;
    logic       data_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    int exp_data  = 0;
    int exp_valid = 0;

    sync_rom dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adr        (adr),
        .data       (data),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    function automatic int ref_word(input int a);
        return (13 * a + 7) % 32;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle at the falling edge, let the rising edge act, then compare with the model.
    task automatic step(input logic e, input int a);
        @(negedge clk);
        en  = e;
        adr = 5'(a);
        @(posedge clk);
        #1;
        if (e) begin
            exp_data  = ref_word(a);
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        check("data", int'(data), exp_data);
        check("valid", int'(data_valid), exp_valid);
    endtask

    int dir_adr [6] = '{11, 8, 15, 23, 27, 1};
    int dir_exp [6] = '{22, 15, 10, 18, 6, 20};
    logic [31:0] seen;
    int distinct;
    int a1;
    int a2;

    initial begin
        // Reset without any clock edge in between.
        #2 rst = 1'b1;
        #1;
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(data_valid), 0);
        @(posedge clk);
        #1;
        check("rst_hold_data", int'(data), 0);
        check("rst_hold_valid", int'(data_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 0);
        check("first_read", int'(data), 7);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, dir_adr[i]);
            check("directed", int'(data), dir_exp[i]);
        end

        step(1'b1, 31);
        check("read31", int'(data), 26);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, int'($urandom_range(0, 31)));
            check("gated_hold", int'(data), 26);
        end

        seen = 32'd0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, i);
            seen[data] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < 32; i++) begin
            distinct += int'(seen[i]);
        end
        check("bijection", distinct, 32);

        // Reset pulse between edges during a sweep.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i);
        end
        #1 rst = 1'b1;
        #1;
        check("mid_rst_data", int'(data), 0);
        check("mid_rst_valid", int'(data_valid), 0);
        #1 rst = 1'b0;
        exp_data  = 0;
        exp_valid = 0;
        for (int i = 10; i < 16; i++) begin
            step(1'b1, i);
        end

        // Address changes between edges must not reach the output.
        for (int k = 0; k < 4; k++) begin
            a1 = int'($urandom_range(0, 31));
            a2 = (a1 + 1 + int'($urandom_range(0, 30))) % 32;
            step(1'b1, a1);
            #2 adr = 5'(a2);
            #1;
            check("no_comb_path", int'(data), ref_word(a1));
            @(posedge clk);
            #1;
            check("next_edge", int'(data), ref_word(a2));
            exp_data = ref_word(a2);
        end

        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
